// File: rtl/chop_freq_monitor.sv
// Chopper clock bank checker: counts rising edges of each chopper clock over a 1 ms gate
// and flags channels whose frequency (kHz) falls outside the planned value +/- TOL.
module chop_freq_monitor #(
  parameter int NCH      = 16,
  parameter int FREF_KHZ = 1000,
  parameter int FCHOP1   = 32,
  parameter int DF       = 4,
  parameter int TOL      = 1,
  parameter int CW       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    CHOP,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [NCH*CW-1:0] FREQ,
  output logic [NCH-1:0]    FAIL,
  output logic              PASS
);

  localparam int              GATE_CYC  = FREF_KHZ;
  localparam int              GW        = $clog2(GATE_CYC + 1);
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYC - 1);
  localparam logic [CW-1:0]   CNT_MAX   = '1;
  localparam logic [CW:0]     TOL_W     = (CW+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, GATE, CHECK} state_t;

  state_t         state;
  logic [NCH-1:0] chop_p0, chop_p1, chop_p2;
  logic [NCH-1:0] rise;
  logic [GW-1:0]  gcnt;
  logic [CW-1:0]  cnt [NCH];
  logic [NCH-1:0] fail_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  // Lower bound clamps at zero so small expected values near TOL never wrap.
  function automatic logic out_of_band(input logic [CW-1:0] c, input logic [CW:0] e);
    logic [CW:0] lo, hi, cx;
    cx = {1'b0, c};
    lo = (e >= TOL_W) ? e - TOL_W : '0;
    hi = e + TOL_W;
    return (cx < lo) || (cx > hi);
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: history flop for edge detection
  always_ff @(posedge CLK) begin
    if (RST) begin
      chop_p0 <= '0;
      chop_p1 <= '0;
      chop_p2 <= '0;
    end else begin
      chop_p0 <= CHOP;
      chop_p1 <= chop_p0;
      chop_p2 <= chop_p1;
    end
  end

  assign rise = chop_p1 & ~chop_p2;

  always_comb begin
    fail_next = '0;
    for (int i = 0; i < NCH; i++)
      fail_next[i] = out_of_band(cnt[i], (CW+1)'(FCHOP1 + i * DF));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      gcnt  <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      FREQ  <= '0;
      FAIL  <= '0;
      PASS  <= 1'b0;
      DONE  <= 1'b0;
      BUSY  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state <= ARM;
            BUSY  <= 1'b1;
          end
        end
        ARM: begin
          gcnt <= '0;
          for (int i = 0; i < NCH; i++) cnt[i] <= '0;
          state <= GATE;
        end
        GATE: begin
          for (int i = 0; i < NCH; i++)
            if (rise[i]) cnt[i] <= sat_inc(cnt[i]);
          if (gcnt == GATE_LAST) state <= CHECK;
          else                   gcnt  <= gcnt + GW'(1);
        end
        CHECK: begin
          for (int i = 0; i < NCH; i++) FREQ[i*CW +: CW] <= cnt[i];
          FAIL  <= fail_next;
          PASS  <= ~|fail_next;
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chop_freq_monitor.sv
// Scoreboard bench for chop_freq_monitor: main process issues measurements and queues
// expected results; a negedge monitor pops and compares whenever DONE or a probe is due.
`timescale 1ns/1ps
module tb_chop_freq_monitor;
  localparam int NCH = 16;
  localparam int CW  = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  wire  [NCH-1:0]    chop;
  logic              busy, done, pass;
  logic [NCH*CW-1:0] freq;
  logic [NCH-1:0]    fail;
  int                fk [NCH];
  int                cyc = 0;

  always #500 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  chop_freq_monitor #(.NCH(NCH), .FREF_KHZ(1000), .FCHOP1(32), .DF(4), .TOL(1), .CW(CW)) dut (
    .CLK(clk), .RST(rst), .CHOP(chop), .START(start),
    .BUSY(busy), .DONE(done), .FREQ(freq), .FAIL(fail), .PASS(pass));

  // Chopper sources with random start phase; fk==0 holds the line low
  for (genvar g = 0; g < NCH; g++) begin : gch
    logic c = 1'b0;
    initial begin
      #($urandom_range(0, 20000));
      forever begin
        if (fk[g] <= 0) begin
          c = 1'b0;
          #1000;
        end else begin
          #(500000.0 / fk[g]);
          c = ~c;
        end
      end
    end
    assign chop[g] = c;
  end

  // Second instance at 4 MHz reference with one 300 kHz channel to exercise saturation
  logic clk2 = 1'b0, rst2 = 1'b1, start2 = 1'b0, chop2 = 1'b0;
  logic busy2, done2, pass2;
  logic [CW-1:0] freq2;
  logic [0:0]    fail2;
  int cyc2 = 0, t2 = 0, d2_n = 0, d2_cyc = 0;
  logic [CW-1:0] d2_freq = '0;
  logic d2_fail = 1'b0, d2_pass = 1'b1;

  always #125 clk2 = ~clk2;
  always @(posedge clk2) cyc2 <= cyc2 + 1;
  initial forever #(500000.0 / 300) chop2 = ~chop2;

  chop_freq_monitor #(.NCH(1), .FREF_KHZ(4000), .FCHOP1(32), .DF(4), .TOL(1), .CW(CW)) dut2 (
    .CLK(clk2), .RST(rst2), .CHOP(chop2), .START(start2),
    .BUSY(busy2), .DONE(done2), .FREQ(freq2), .FAIL(fail2), .PASS(pass2));

  initial begin
    repeat (4) @(negedge clk2);
    rst2 = 1'b0;
    repeat (40) @(negedge clk2);
    t2 = cyc2;
    start2 = 1'b1;
    @(negedge clk2);
    start2 = 1'b0;
  end

  always @(negedge clk2) begin
    if (done2) begin
      d2_n    <= d2_n + 1;
      d2_cyc  <= cyc2;
      d2_freq <= freq2;
      d2_fail <= fail2[0];
      d2_pass <= pass2;
    end
  end

  typedef struct packed {
    int                cyc;
    logic [NCH*CW-1:0] f;
    logic [NCH-1:0]    exact;
    logic [NCH-1:0]    fail;
    logic              pass;
  } exp_t;

  typedef struct packed {
    int   cyc;
    logic busy;
    logic zero;
  } probe_t;

  exp_t   q[$];
  probe_t pq[$];
  int     errors = 0, checks = 0;
  logic   finish_req = 1'b0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(cyc == e.cyc, "done_cycle", cyc, e.cyc);
        for (int i = 0; i < NCH; i++) begin
          int a, x;
          a = int'(freq[i*CW +: CW]);
          x = int'(e.f[i*CW +: CW]);
          if (e.exact[i]) chk(a == x, $sformatf("freq[%0d]", i), a, x);
          else            chk(a >= x - 1 && a <= x + 1, $sformatf("freq[%0d]", i), a, x);
        end
        chk(fail == e.fail, "fail_mask", fail, e.fail);
        chk(pass == e.pass, "pass", pass, e.pass);
      end
    end
    for (int k = pq.size() - 1; k >= 0; k--) begin
      if (pq[k].cyc == cyc) begin
        chk(busy == pq[k].busy, "busy", busy, pq[k].busy);
        if (pq[k].zero)
          chk(freq == '0 && fail == '0 && !pass && !done, "cleared_outputs",
              {done, pass, |freq, fail}, 0);
        pq.delete(k);
      end
    end
    if (finish_req) begin
      chk(q.size() == 0, "missing_done", q.size(), 0);
      chk(pq.size() == 0, "missed_probes", pq.size(), 0);
      chk(d2_n == 1, "sat_done_count", d2_n, 1);
      chk(d2_cyc == t2 + 4003, "sat_done_cycle", d2_cyc, t2 + 4003);
      chk(d2_freq == 8'd255, "sat_freq0", d2_freq, 255);
      chk(d2_fail == 1'b1, "sat_fail0", d2_fail, 1);
      chk(d2_pass == 1'b0, "sat_pass", d2_pass, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic probe(input int c, input logic b, input logic z);
    probe_t p;
    p.cyc = c; p.busy = b; p.zero = z;
    pq.push_back(p);
  endtask

  // Called at a negedge; START is sampled at the next posedge (relative cycle 0)
  task automatic measure(output int t0, input logic [NCH-1:0] fail_exp);
    exp_t e;
    t0 = cyc;
    e.cyc = t0 + 1003;
    for (int i = 0; i < NCH; i++) begin
      e.f[i*CW +: CW] = 8'(fk[i]);
      e.exact[i]      = (fk[i] == 0);
    end
    e.fail = fail_exp;
    e.pass = (fail_exp == '0);
    q.push_back(e);
    probe(t0 + 1, 1'b1, 1'b0);
    probe(t0 + 1002, 1'b1, 1'b0);
    probe(t0 + 1003, 1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t;

  initial begin
    for (int i = 0; i < NCH; i++) fk[i] = 32 + 4 * i;
    repeat (3) @(negedge clk);
    probe(cyc + 1, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Nominal, then an immediate restart in the DONE cycle
    measure(t, '0);
    wait_until(t + 1003);
    measure(t, '0);
    wait_until(t + 1003);

    // Channel 5 off-plan
    fk[5] = 60;
    repeat (30) @(negedge clk);
    measure(t, 16'h0020);
    wait_until(t + 1003);

    // Stuck channel 15, then recovered
    fk[5] = 52;
    fk[15] = 0;
    repeat (30) @(negedge clk);
    measure(t, 16'h8000);
    wait_until(t + 1003);
    fk[15] = 92;
    repeat (30) @(negedge clk);
    measure(t, '0);
    wait_until(t + 1003);

    // Extra START pulses while busy and in CHECK are ignored
    repeat (10) @(negedge clk);
    measure(t, '0);
    probe(t + 500, 1'b1, 1'b0);
    probe(t + 1004, 1'b0, 1'b0);
    wait_until(t + 500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 1002);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 1010);

    // Reset mid-gate aborts without DONE; a fresh run then completes
    t = cyc;
    probe(t + 602, 1'b0, 1'b1);
    probe(t + 1003, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 600);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_until(t + 1010);
    measure(t, '0);
    wait_until(t + 1010);

    finish_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_stalled: got 0, required 1");
    $fatal(1, "monitor did not finish");
  end

endmodule
